trap_sequencer: RTL
===================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 The block SHALL have the parameter NWINDOWS, default 8, giving the number of register windows, used for CWP wrap.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port trap_req, input, 9 bits, with these synchronous trap requests:
- [0] instr_access, tt 0x01
- [1] illegal_instr, tt 0x02
- [2] privileged, tt 0x03
- [3] fp_disabled, tt 0x04
- [4] win_overflow, tt 0x05
- [5] win_underflow, tt 0x06
- [6] mem_not_aligned, tt 0x07
- [7] data_access, tt 0x09
- [8] div_zero, tt 0x2A
REQ-005 The block SHALL have the port ticc_req, input, 1 bit, together with ticc_num, input, 7 bits: a Ticc instruction trap, tt = 0x80 + ticc_num.
REQ-006 The block SHALL have the port irl, input, 4 bits: the external interrupt level.
REQ-007 The block SHALL have the port pil, input, 4 bits: the PSR processor interrupt level.
REQ-008 The block SHALL have the port et, input, 1 bit: the PSR enable-traps bit.
REQ-009 The block SHALL have the port cwp_in, input, 5 bits: the current window pointer.
REQ-010 The block SHALL have the port tba_in, input, 20 bits: the TBA field from the trap base register.
REQ-011 The block SHALL have the port redirect_ready, input, 1 bit: the fetch unit accepts the redirect.
REQ-012 The block SHALL have the port tt_out, output, 8 bits: the trap type to be written into the trap base register.
REQ-013 The block SHALL have the port tt_wr, output, 1 bit: the write strobe for tt_out.
REQ-014 The block SHALL have the port flush, output, 1 bit: kill all in-flight instructions.
REQ-015 The block SHALL have the port save_en, output, 1 bit: write PC/nPC to the locals of the new window.
REQ-016 The block SHALL have the port cwp_out, output, 5 bits: the new CWP, valid while save_en is high.
REQ-017 The block SHALL have the port psr_trap, output, 1 bit: a one-cycle strobe that sets S, copies S to PS and clears ET.
REQ-018 The block SHALL have the port redirect_valid, output, 1 bit: the trap vector is valid.
REQ-019 The block SHALL have the port redirect_pc, output, 32 bits: the trap vector address.
REQ-020 The block SHALL have the port error_mode, output, 1 bit: the processor is halted in error mode.
REQ-021 The block SHALL have the port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-022 The block SHALL implement the states IDLE, SAVE, VECTOR and ERROR.
REQ-023 In IDLE, the highest-priority pending event SHALL be selected in this order: trap_req bit 0 first through bit 8, then ticc_req, then the interrupt.
REQ-024 An interrupt SHALL be pending only when et=1, irl!=0, and (irl==15 or irl>pil); its tt SHALL be 0x10+irl.
REQ-025 When the selected event is a synchronous trap or Ticc and et=0, the block SHALL assert flush and enter ERROR.
REQ-026 Otherwise, in IDLE with an event pending, the block SHALL latch the tt, assert flush for that cycle, and enter SAVE.
REQ-027 SAVE SHALL last exactly one cycle, asserting the following for that cycle, then moving to VECTOR:
- tt_wr=1 with tt_out equal to the latched tt
- save_en=1
- psr_trap=1
- cwp_out=(cwp_in==0) ? NWINDOWS-1 : cwp_in-1
REQ-028 In VECTOR, redirect_valid SHALL be 1 and redirect_pc SHALL equal {tba_in, latched tt, 4'b0000}.
REQ-029 redirect_valid and redirect_pc SHALL remain stable until redirect_ready=1 is sampled; the transition to IDLE SHALL occur on that edge.
REQ-030 The ERROR state SHALL hold error_mode=1 and ignore all inputs until rst.
REQ-031 Requests arriving while busy=1 SHALL be ignored and not queued; the requester re-raises them after the restart.
REQ-032 When no event is pending in IDLE, all strobes SHALL be 0.
REQ-033 tt_wr, save_en and psr_trap SHALL each be high for exactly one cycle per trap; flush SHALL be high for exactly one cycle.
REQ-034 tt_out SHALL hold the last latched tt between traps.

Reset
REQ-035 While rst=1 at a clock edge, the block SHALL enter IDLE, including from ERROR or mid-sequence, and drive these outputs to 0:
- tt_out=0x00
- tt_wr, flush, save_en, psr_trap, redirect_valid, error_mode, busy
- cwp_out=0
- redirect_pc=0
REQ-036 Reset SHALL take priority over every request in the same cycle.

Verification
REQ-037 The bench SHALL drive trap_req=0x006 with et=1, cwp_in=0, tba_in=0x40000, and check:
- the next cycle gives tt_out=0x02, tt_wr=1, cwp_out=7
- the cycle after gives redirect_pc=0x40000020
REQ-038 The bench SHALL drive ticc_req=1, ticc_num=0x05, irl=15, et=1, and check tt=0x85 (Ticc beats the interrupt) and redirect_pc=tba<<12|0x850.
REQ-039 The bench SHALL drive irl=5, pil=5, et=1 and check no trap; with pil=4 it SHALL check tt=0x15; with irl=15, pil=15 it SHALL check tt=0x1F.
REQ-040 The bench SHALL drive trap_req[8]=1 with et=0 and check flush=1 followed by error_mode=1 held; after rst=1 it SHALL check error_mode=0 and the state is IDLE.
REQ-041 The bench SHALL hold redirect_ready=0 for 5 cycles in VECTOR and check redirect_valid is held with redirect_pc unchanged and a new trap_req ignored; after redirect_ready=1 it SHALL check the state is IDLE next cycle.
REQ-042 The bench SHALL assert rst during SAVE and check all outputs are 0 the next cycle and that no redirect occurs.

Source files
------------

// File: rtl/trap_sequencer.sv
// Trap sequencer: arbitrates synchronous traps, Ticc and interrupts, then
// walks flush -> window save -> vector redirect, or halts in error mode.
module trap_sequencer #(
    parameter int unsigned NWINDOWS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  trap_req,
    input  logic        ticc_req,
    input  logic [6:0]  ticc_num,
    input  logic [3:0]  irl,
    input  logic [3:0]  pil,
    input  logic        et,
    input  logic [4:0]  cwp_in,
    input  logic [19:0] tba_in,
    input  logic        redirect_ready,
    output logic [7:0]  tt_out,
    output logic        tt_wr,
    output logic        flush,
    output logic        save_en,
    output logic [4:0]  cwp_out,
    output logic        psr_trap,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        error_mode,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam logic [4:0] CWP_MAX = 5'(NWINDOWS - 1);

    state_t      state_q, state_d;
    logic [7:0]  tt_q;
    logic [31:0] pc_q;

    logic        sel_valid;
    logic        sel_sync;
    logic [7:0]  sel_tt;
    logic        irq_pending;
    logic        latch_tt;

    // Trap type for each synchronous trap_req bit.
    function automatic logic [7:0] trap_tt(input logic [3:0] idx);
        case (idx)
            4'd0:    trap_tt = 8'h01;
            4'd1:    trap_tt = 8'h02;
            4'd2:    trap_tt = 8'h03;
            4'd3:    trap_tt = 8'h04;
            4'd4:    trap_tt = 8'h05;
            4'd5:    trap_tt = 8'h06;
            4'd6:    trap_tt = 8'h07;
            4'd7:    trap_tt = 8'h09;
            4'd8:    trap_tt = 8'h2A;
            default: trap_tt = 8'h00;
        endcase
    endfunction

    // Priority select: trap_req bit 0 .. bit 8, then Ticc, then interrupt.
    always_comb begin
        sel_valid   = 1'b0;
        sel_sync    = 1'b0;
        sel_tt      = '0;
        irq_pending = et && (irl != 4'd0) && ((irl == 4'hF) || (irl > pil));
        for (int unsigned i = 0; i < 9; i++) begin
            if (trap_req[4'(i)] && !sel_valid) begin
                sel_valid = 1'b1;
                sel_sync  = 1'b1;
                sel_tt    = trap_tt(4'(i));
            end
        end
        if (!sel_valid && ticc_req) begin
            sel_valid = 1'b1;
            sel_sync  = 1'b1;
            sel_tt    = {1'b1, ticc_num};
        end else if (!sel_valid && irq_pending) begin
            sel_valid = 1'b1;
            sel_tt    = {4'h1, irl};
        end
    end

    // Next-state and output decode; reset forces every strobe low.
    always_comb begin
        state_d        = state_q;
        latch_tt       = 1'b0;
        tt_wr          = 1'b0;
        flush          = 1'b0;
        save_en        = 1'b0;
        cwp_out        = '0;
        psr_trap       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        error_mode     = 1'b0;
        busy           = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    flush = 1'b1;
                    if (sel_sync && !et) begin
                        state_d = ERROR;
                    end else begin
                        latch_tt = 1'b1;
                        state_d  = SAVE;
                    end
                end
            end
            SAVE: begin
                tt_wr    = 1'b1;
                save_en  = 1'b1;
                psr_trap = 1'b1;
                cwp_out  = (cwp_in == 5'd0) ? CWP_MAX : cwp_in - 5'd1;
                state_d  = VECTOR;
            end
            VECTOR: begin
                redirect_valid = 1'b1;
                redirect_pc    = pc_q;
                if (redirect_ready) state_d = IDLE;
            end
            ERROR: begin
                error_mode = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d        = IDLE;
            latch_tt       = 1'b0;
            tt_wr          = 1'b0;
            flush          = 1'b0;
            save_en        = 1'b0;
            cwp_out        = '0;
            psr_trap       = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            error_mode     = 1'b0;
            busy           = 1'b0;
        end
    end

    // State, latched trap type and vector address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tt_q    <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (latch_tt) tt_q <= sel_tt;
            // Vector is captured on leaving SAVE so it stays stable while stalled.
            if (state_q == SAVE) pc_q <= {tba_in, tt_q, 4'b0000};
        end
    end

    assign tt_out = tt_q;

endmodule
